// File: rtl/io_port_unit.sv
// I/O port block: strobe-fed input FIFO with show-ahead head, plus an output
// holding register with valid/ack handshake and sticky drop flags.
module io_port_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              strobe,
    input  logic              in_pop,
    output logic [DATA_W-1:0] in_rd_data,
    output logic              in_empty,
    output logic              in_full,
    output logic [ADDR_W:0]   in_count,
    output logic              in_overflow,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              out_load,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              out_overrun,
    input  logic              flag_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              strobe_d;

    logic push_req;
    logic pop_ok;
    logic push_ok;
    logic ovf_set;
    logic ovr_set;

    always_comb begin
        in_empty = (count == '0);
        in_full  = (count == CNT_W'(DEPTH));
        push_req = strobe & ~strobe_d;
        pop_ok   = in_pop & ~in_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_ok  = push_req & (~in_full | pop_ok);
        ovf_set  = push_req & in_full & ~pop_ok;
        ovr_set  = out_load & out_valid & ~out_ack;
    end

    assign in_count   = count;
    assign in_rd_data = in_empty ? '0 : mem[rd_ptr];

    // strobe_d resets high so a strobe already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            strobe_d <= 1'b1;
        end else begin
            strobe_d <= strobe;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_data  <= bus_data;
            out_valid <= 1'b1;
        end else if (out_ack) begin
            out_valid <= 1'b0;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            in_overflow <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            in_overflow <= ovf_set | (in_overflow & ~flag_clr);
            out_overrun <= ovr_set | (out_overrun & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// Bench for io_port_unit: per-cycle vector table plus a hand-written async reset sequence.
module tb_io_port_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              strobe;
    logic              in_pop;
    logic [DATA_W-1:0] in_rd_data;
    logic              in_empty;
    logic              in_full;
    logic [ADDR_W:0]   in_count;
    logic              in_overflow;
    logic [DATA_W-1:0] bus_data;
    logic              out_load;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ack;
    logic              out_overrun;
    logic              flag_clr;

    io_port_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .clear(clear), .in_data(in_data), .strobe(strobe), .in_pop(in_pop),
        .in_rd_data(in_rd_data), .in_empty(in_empty), .in_full(in_full),
        .in_count(in_count), .in_overflow(in_overflow), .bus_data(bus_data),
        .out_load(out_load), .out_data(out_data), .out_valid(out_valid),
        .out_ack(out_ack), .out_overrun(out_overrun), .flag_clr(flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic [31:0] din;
        logic        pop;
        logic        load;
        logic [31:0] bus;
        logic        ack;
        logic        fclr;
        int          cnt;
        logic [31:0] rd;
        logic        ovf;
        logic [31:0] od;
        logic        ov;
        logic        ovr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t mk(logic stb, logic [31:0] din, logic pop, logic load,
                                logic [31:0] bus, logic ack, logic fclr, int cnt,
                                logic [31:0] rd, logic ovf, logic [31:0] od, logic ov,
                                logic ovr);
        vec_t v;
        v.stb = stb; v.din = din; v.pop = pop; v.load = load; v.bus = bus;
        v.ack = ack; v.fclr = fclr; v.cnt = cnt; v.rd = rd; v.ovf = ovf;
        v.od = od; v.ov = ov; v.ovr = ovr;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(string tag, int cnt, logic [31:0] rd, logic ovf,
                             logic [31:0] od, logic ov, logic ovr);
        chk({tag, " in_count"}, 32'(in_count), 32'(cnt));
        chk({tag, " in_rd_data"}, in_rd_data, rd);
        chk({tag, " in_empty"}, 32'(in_empty), 32'(cnt == 0));
        chk({tag, " in_full"}, 32'(in_full), 32'(cnt == DEPTH));
        chk({tag, " in_overflow"}, 32'(in_overflow), 32'(ovf));
        chk({tag, " out_data"}, out_data, od);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " out_overrun"}, 32'(out_overrun), 32'(ovr));
    endtask

    task automatic pulse(logic [31:0] d);
        strobe = 1'b1; in_data = d;
        @(posedge clk); #1;
        strobe = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // strobe held high across reset release, then a 3-cycle pulse of 0x55
        vecs.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        vecs.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        vecs.push_back(mk(1, 'h55,  0, 0, 0, 0, 0, 1, 'h55,  0, 0, 0, 0));
        vecs.push_back(mk(1, 'h55,  0, 0, 0, 0, 0, 1, 'h55,  0, 0, 0, 0));
        vecs.push_back(mk(1, 'h66,  0, 0, 0, 0, 0, 1, 'h55,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 'h55,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        // five pulses 1..5 into a 4-deep FIFO
        vecs.push_back(mk(1, 1,     0, 0, 0, 0, 0, 1, 1,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 1,     0, 0, 0, 0));
        vecs.push_back(mk(1, 2,     0, 0, 0, 0, 0, 2, 1,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 2, 1,     0, 0, 0, 0));
        vecs.push_back(mk(1, 3,     0, 0, 0, 0, 0, 3, 1,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 3, 1,     0, 0, 0, 0));
        vecs.push_back(mk(1, 4,     0, 0, 0, 0, 0, 4, 1,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 4, 1,     0, 0, 0, 0));
        vecs.push_back(mk(1, 5,     0, 0, 0, 0, 0, 4, 1,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 4, 1,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 3, 2,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 2, 3,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 1, 4,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 1, 0, 0,     0, 0, 0, 0));
        // fill, then pop + push in the same cycle while full
        vecs.push_back(mk(1, 'h11,  0, 0, 0, 0, 0, 1, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(1, 'h12,  0, 0, 0, 0, 0, 2, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 2, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(1, 'h13,  0, 0, 0, 0, 0, 3, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 3, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(1, 'h14,  0, 0, 0, 0, 0, 4, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 4, 'h11,  0, 0, 0, 0));
        vecs.push_back(mk(1, 9,     1, 0, 0, 0, 0, 4, 'h12,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 3, 'h13,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 2, 'h14,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 1, 9,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        // push + pop while empty, then while partly filled
        vecs.push_back(mk(1, 'h77,  1, 0, 0, 0, 0, 1, 'h77,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        vecs.push_back(mk(1, 'h21,  0, 0, 0, 0, 0, 1, 'h21,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0, 0, 0, 1, 'h21,  0, 0, 0, 0));
        vecs.push_back(mk(1, 'h22,  1, 0, 0, 0, 0, 1, 'h22,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,     1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        // output register handshake, overrun, flag clear priority
        vecs.push_back(mk(0, 0,     0, 1, 'h85, 0, 0, 0, 0,  0, 'h85, 1, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0,    1, 0, 0, 0,  0, 'h85, 0, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0,    1, 0, 0, 0,  0, 'h85, 0, 0));
        vecs.push_back(mk(0, 0,     0, 1, 'h86, 0, 0, 0, 0,  0, 'h86, 1, 0));
        vecs.push_back(mk(0, 0,     0, 1, 'h87, 0, 0, 0, 0,  0, 'h87, 1, 1));
        vecs.push_back(mk(0, 0,     0, 0, 0,    0, 1, 0, 0,  0, 'h87, 1, 0));
        vecs.push_back(mk(0, 0,     0, 1, 'h88, 0, 1, 0, 0,  0, 'h88, 1, 1));
        vecs.push_back(mk(0, 0,     0, 0, 0,    0, 1, 0, 0,  0, 'h88, 1, 0));
        vecs.push_back(mk(0, 0,     0, 1, 'h99, 1, 0, 0, 0,  0, 'h99, 1, 0));
        vecs.push_back(mk(0, 0,     0, 0, 0,    1, 0, 0, 0,  0, 'h99, 0, 0));
        vecs.push_back(mk(0, 0,     0, 1, 'hA0, 1, 0, 0, 0,  0, 'hA0, 1, 0));

        clear = 1'b1; strobe = 1'b1; in_data = '0; in_pop = 1'b0;
        bus_data = '0; out_load = 1'b0; out_ack = 1'b0; flag_clr = 1'b0;
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        #2 clear = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            strobe = vecs[i].stb; in_data = vecs[i].din; in_pop = vecs[i].pop;
            out_load = vecs[i].load; bus_data = vecs[i].bus; out_ack = vecs[i].ack;
            flag_clr = vecs[i].fclr;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rd, vecs[i].ovf,
                      vecs[i].od, vecs[i].ov, vecs[i].ovr);
        end

        strobe = 1'b0; in_pop = 1'b0; out_load = 1'b0; out_ack = 1'b0; flag_clr = 1'b0;
        @(posedge clk); #1;
        pulse(32'hC1);
        pulse(32'hC2);
        pulse(32'hC3);
        check_all("pre_clear", 3, 32'hC1, 0, 32'hA0, 1, 0);

        // asynchronous clear between edges, with strobe held high across release
        #3;
        strobe = 1'b1; in_data = 32'hDD;
        clear = 1'b1;
        #1;
        check_all("async_clear", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk); #1;
        check_all("post_clear_strobe_held", 0, 0, 0, 0, 0, 0);
        strobe = 1'b0;
        @(posedge clk); #1;
        pulse(32'hE5);
        check_all("post_clear_push", 1, 32'hE5, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
Parameterised I/O port block for the datapath. It replaces the single-register in/out ports with an input FIFO, filled by edge-detected external strobes, and an output holding register with a valid/ack handshake. The bus-side controls (in_pop for "in Ra", out_load for "out Ra") are driven by the control unit. Sticky overflow and overrun flags report any data the block drops.

Parameters:
DATA_W  32  width of port data and bus
ADDR_W  2  FIFO address width; depth = 2**ADDR_W (ADDR_W >= 1)

Ports:
clk  in  1  system clock, rising-edge
clear  in  1  asynchronous active-high reset
in_data  in  DATA_W  external input data, sampled on a strobe rising edge
strobe  in  1  external load strobe, level signal synchronous to clk
in_pop  in  1  bus side consumes the FIFO head this cycle
in_rd_data  out  DATA_W  FIFO head (show-ahead); 0 when empty
in_empty  out  1  FIFO holds 0 entries
in_full  out  1  FIFO holds 2**ADDR_W entries
in_count  out  ADDR_W+1  current FIFO occupancy
in_overflow  out  1  sticky: a push was dropped because the FIFO was full
bus_data  in  DATA_W  datapath bus value for out_load
out_load  in  1  capture bus_data into the output register
out_data  out  DATA_W  output port register
out_valid  out  1  out_data not yet acknowledged externally
out_ack  in  1  external consumer accepted out_data
out_overrun  out  1  sticky: out_load overwrote unacknowledged data
flag_clr  in  1  synchronous clear of in_overflow and out_overrun

Behaviour:
- Reset (clear=1, asynchronous):
  - FIFO pointers, in_count, out_data, out_valid, in_overflow and out_overrun all go to 0.
  - in_empty=1, in_full=0, in_rd_data=0.
  - The strobe delay register strobe_d resets to 1, so a strobe held high through reset release does not push.
  - Reset mid-operation discards all FIFO contents immediately.
- Push:
  - push = strobe & ~strobe_d, evaluated at the clk edge; strobe_d <= strobe every cycle.
  - Only one push per strobe pulse, regardless of how long strobe stays high.
  - On push with room: mem[wr_ptr] <= in_data, wr_ptr increments (wraps modulo depth), in_count increments.
- Pop:
  - in_pop with in_empty=0: rd_ptr increments (wraps), in_count decrements.
  - in_pop while empty is ignored; no flag is raised.
- in_rd_data is combinational from mem[rd_ptr], forced to 0 when empty. Push-to-visible latency is 1 cycle after the edge.
- Simultaneous push and pop:
  - Not full, not empty: both occur and in_count is unchanged.
  - Full: the pop frees a slot, the push is accepted, in_count stays at depth, in_overflow is not set.
  - Empty: the push occurs, the pop is ignored, in_count becomes 1.
- Push while full with no pop: data is dropped, the FIFO is unchanged, in_overflow <= 1.
- Output register:
  - out_load: out_data <= bus_data, out_valid <= 1 on the next edge.
  - out_ack with out_valid=1: out_valid <= 0. out_ack with out_valid=0 is ignored.
  - out_load with out_ack in the same cycle: new data is captured, out_valid stays 1, no overrun.
  - out_load while out_valid=1 and out_ack=0: data is overwritten and out_overrun <= 1.
- Flags:
  - flag_clr clears both flags next edge.
  - If a flag-setting event coincides with flag_clr, the set wins.
- in_full = (in_count == 2**ADDR_W); in_empty = (in_count == 0). Both are combinational from in_count.

Test Plan:
1. Reset, then hold strobe high → in_count=0, no push. Drop strobe, then give one 3-cycle strobe pulse with in_data=32'h55 → in_count=1, in_rd_data=32'h55 one cycle after the edge.
2. Five strobe pulses with data 1..5 at ADDR_W=2 → in_full=1, in_count=4, in_overflow=1. Four pops return 1,2,3,4, then in_empty=1 and in_rd_data=0.
3. FIFO full, pop and strobe edge (data 9) in the same cycle → in_count stays 4, in_overflow stays 0, head advances, 9 is read last.
4. out_load with bus_data=32'h85 → out_data=32'h85, out_valid=1. out_ack → out_valid=0. A second out_load before any ack → out_overrun=1, out_data=second value.
5. out_load and out_ack in the same cycle with out_valid=1 → out_valid stays 1, out_overrun stays 0, out_data updated.
6. Assert clear asynchronously mid-cycle with 3 entries queued and out_valid=1 → all outputs 0 and in_empty=1 immediately, without waiting for a clk edge.
